// File: rtl/req_arbiter_4_if.sv
// req_arbiter_4_if: request/grant bundle between requesters and the arbiter
interface req_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       v;
  logic       timeout;
  modport master(output req, input gnt, gnt_id, v, timeout);
  modport slave(input req, output gnt, gnt_id, v, timeout);
endinterface

// File: rtl/req_arbiter_4.sv
// req_arbiter_4: four-way arbiter with hold timeout and turnaround; ROUND_ROBIN_EN selects round-robin
module req_arbiter_4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  req_arbiter_4_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t           r_state, w_state_nx;
  logic [3:0]       r_gnt, w_gnt_nx, r_block, w_block_set, w_ereq;
  logic [1:0]       r_gnt_id, w_gnt_id_nx, w_win;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_timeout, w_timeout_nx;
  assign w_ereq      = bus.req & ~r_block;
  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.v       = |r_gnt;
  assign bus.timeout = r_timeout;
`ifdef ROUND_ROBIN_EN
  // winner search: descending from last owner - 1, last owner checked last
  always_comb begin
    w_win = 2'd0;
    for (int k = 4; k >= 1; k--) if (w_ereq[r_gnt_id - 2'(k)]) w_win = r_gnt_id - 2'(k);
  end
`else
  // winner search: highest pending index wins
  always_comb begin
    w_win = 2'd0;
    for (int k = 0; k < 4; k++) if (w_ereq[k]) w_win = 2'(k);
  end
`endif
  // next-state and output decode; IDLE and RELEASE arbitrate identically
  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_gnt_id_nx  = r_gnt_id;
    w_cnt_nx     = r_cnt;
    w_timeout_nx = 1'b0;
    w_block_set  = 4'b0000;
    case (r_state)
      GRANT: begin
        w_cnt_nx = r_cnt + 1'b1;
        if (!bus.req[r_gnt_id]) begin
          w_state_nx = RELEASE;
          w_gnt_nx   = 4'b0000;
        end else if (r_cnt == CNT_W'(MAX_HOLD - 1)) begin
          w_state_nx            = RELEASE;
          w_gnt_nx              = 4'b0000;
          w_timeout_nx          = 1'b1;
          w_block_set[r_gnt_id] = 1'b1;
        end
      end
      default: begin
        w_state_nx  = |w_ereq ? GRANT : IDLE;
        w_gnt_nx    = |w_ereq ? 4'(1) << w_win : 4'b0000;
        w_gnt_id_nx = |w_ereq ? w_win : r_gnt_id;
        w_cnt_nx    = '0;
      end
    endcase
  end
  // state and output registers; a requester's block lifts whenever its line is seen low
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= 4'b0000;
      r_gnt_id  <= 2'd0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_block   <= 4'b0000;
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_gnt_id  <= w_gnt_id_nx;
      r_cnt     <= w_cnt_nx;
      r_timeout <= w_timeout_nx;
      r_block   <= (r_block | w_block_set) & bus.req;
    end
  end
endmodule
